// File: rtl/addr_gen_out.sv
`default_nettype none
// ============================================================================
//  Module   : addr_gen_out
//  Function : Unload-side address generator for the FFT result memory.
//             Reads one frame of 2^AddrWidth samples back out of 4 SRAM
//             banks (permuted row order) and emits them as a natural-order
//             valid/ready stream. A 2-entry output buffer plus credit-based
//             read issue absorbs the 1-cycle SRAM latency under backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module addr_gen_out #(
   parameter int AddrWidth = 7,   // log2 of frame length; must be >= 6
   parameter int DataWidth = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   output logic [3:0]             rd_en_o,
   output logic [AddrWidth-3:0]   rd_addr_o,
   input  logic [4*DataWidth-1:0] rd_data_i,
   output logic [DataWidth-1:0]   data_o,
   output logic [AddrWidth-1:0]   idx_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   last_o,
   output logic                   busy_o,
   output logic                   done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                 state, state_next;
   logic [AddrWidth-1:0]   k, k_next;
   logic [AddrWidth-3:0]   row;
   logic [AddrWidth-3:0]   addr_hold;
   logic [1:0]             bank;
   logic                   issue;
   logic                   done_next;

   // Read-return tracking: bank and index of the read issued last cycle.
   logic                   inflight;
   logic [1:0]             bank_q;
   logic [AddrWidth-1:0]   k_q;

   // Output buffer: head lives directly in the output registers.
   logic [1:0]             occ;
   logic [DataWidth-1:0]   tail_data;
   logic [AddrWidth-1:0]   tail_idx;
   logic                   tail_last;

   logic                   push, pop;
   logic [2:0]             credit;
   logic [DataWidth-1:0]   push_data;
   logic                   push_last;

   // Bank from the top two index bits; row low bits undo the loader permutation.
   assign bank      = k[AddrWidth-1 -: 2];
   assign row       = {k[AddrWidth-3:3], k[1:0], k[2]};

   assign valid_o   = (occ != 2'd0);
   assign pop       = valid_o & ready_i;
   assign push      = inflight;
   assign credit    = {1'b0, occ} + {2'b00, inflight};
   assign push_data = rd_data_i[32'(bank_q) * DataWidth +: DataWidth];
   assign push_last = &k_q;
   assign busy_o    = (state != IDLE);

   assign rd_en_o   = issue ? (4'b0001 << bank) : 4'b0000;
   assign rd_addr_o = issue ? row : addr_hold;

   // Next-state, issue decision and address counter advance.
   always_comb begin
      state_next = state;
      k_next     = k;
      issue      = 1'b0;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               state_next = RUN;
               k_next     = '0;
            end
         end
         RUN: begin
            // Slot free once buffered + in-flight entries, less this pop, < 2.
            issue = (credit < (3'd2 + {2'b00, pop}));
            if (issue) begin
               k_next = k + AddrWidth'(1);
               if (&k) state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && last_o) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Control registers: state, issue counter, held address, read-return tags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         k         <= '0;
         addr_hold <= '0;
         done_o    <= 1'b0;
         inflight  <= 1'b0;
         bank_q    <= 2'd0;
         k_q       <= '0;
      end else begin
         state    <= state_next;
         k        <= k_next;
         done_o   <= done_next;
         inflight <= issue;
         if (issue) begin
            addr_hold <= row;
            bank_q    <= bank;
            k_q       <= k;
         end
      end
   end

   // Two-entry output buffer: head in output registers, one tail slot behind.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         occ       <= 2'd0;
         data_o    <= '0;
         idx_o     <= '0;
         last_o    <= 1'b0;
         tail_data <= '0;
         tail_idx  <= '0;
         tail_last <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  data_o <= push_data;
                  idx_o  <= k_q;
                  last_o <= push_last;
               end else begin
                  tail_data <= push_data;
                  tail_idx  <= k_q;
                  tail_last <= push_last;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               if (occ == 2'd2) begin
                  data_o <= tail_data;
                  idx_o  <= tail_idx;
                  last_o <= tail_last;
               end
               occ <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  data_o    <= tail_data;
                  idx_o     <= tail_idx;
                  last_o    <= tail_last;
                  tail_data <= push_data;
                  tail_idx  <= k_q;
                  tail_last <= push_last;
               end else begin
                  data_o <= push_data;
                  idx_o  <= k_q;
                  last_o <= push_last;
               end
            end
            default: ;
         endcase
      end
   end

   // The credit rule keeps occ + inflight <= 2, so a push into a full buffer
   // without a simultaneous pop must never happen.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && !pop && occ == 2'd2));

endmodule
`default_nettype wire
